// File: rtl/mem_log_reader.sv
// mem_log_reader: walks the mem_log capture memory from address 0 up to a
// latched last address once the log is full, and streams each {tx,rx} word
// out on a valid/ready interface with a last-word flag.
//
// All outputs are registered. Each transition loads the output values of the
// state it enters, so o_read is high for exactly the FETCH cycle, o_valid for
// exactly the SEND cycles, and so on.
module mem_log_reader #(
  parameter int NB_ADDR    = 15,
  parameter int NB_DATA    = 32,
  parameter int RD_LATENCY = 1     // 1..4 cycles from o_read to valid i_data
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [NB_ADDR-1:0] i_last_addr,
  input  logic               i_mem_full,
  output logic               o_read,
  output logic [NB_ADDR-1:0] o_address,
  input  logic [NB_DATA-1:0] i_data,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_last,
  output logic               o_busy,
  output logic               o_done
);

  // Wide enough for any supported latency; RD_LATENCY-1 is at most 3.
  localparam int NB_WAIT = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_FETCH,
    ST_WAIT,
    ST_SEND,
    ST_DONE
  } state_t;

  state_t               r_state;
  logic [NB_ADDR-1:0]   r_cnt;
  logic [NB_ADDR-1:0]   r_last_addr;
  logic [NB_WAIT-1:0]   r_wait_cnt;
  logic                 r_read;
  logic [NB_ADDR-1:0]   r_address;
  logic [NB_DATA-1:0]   r_data;
  logic                 r_valid;
  logic                 r_last;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_xfer;
  logic                 w_is_last;
  logic                 w_wait_end;

  // A beat leaves when the consumer accepts it.
  assign w_xfer     = r_valid && i_ready;
  // Exact equality against the latched bound: the walk ends before the
  // counter could ever wrap, even at full depth.
  assign w_is_last  = (r_cnt == r_last_addr);
  // Final WAIT cycle is the one on which the memory presents the word.
  assign w_wait_end = (r_wait_cnt == NB_WAIT'(RD_LATENCY - 1));

  // Control FSM with registered outputs; abort outranks every other request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_last_addr <= '0;
      r_wait_cnt  <= '0;
      r_read      <= 1'b0;
      r_address   <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // o_read is a single-cycle strobe; only the FETCH entries raise it.
      r_read <= 1'b0;

      if (i_abort) begin
        // Drop everything, including a word waiting in SEND.
        r_state    <= ST_IDLE;
        r_cnt      <= '0;
        r_wait_cnt <= '0;
        r_valid    <= 1'b0;
        r_last     <= 1'b0;
        r_busy     <= 1'b0;
        r_done     <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE, ST_DONE: begin
            if (i_start) begin
              r_last_addr <= i_last_addr;
              r_cnt       <= '0;
              r_done      <= 1'b0;
              r_busy      <= 1'b1;
              if (i_mem_full) begin
                r_state   <= ST_FETCH;
                r_read    <= 1'b1;
                r_address <= '0;
              end else begin
                r_state   <= ST_ARMED;
              end
            end
          end

          ST_ARMED: begin
            // Hold off until mem_log has finished capturing.
            if (i_mem_full) begin
              r_state   <= ST_FETCH;
              r_read    <= 1'b1;
              r_address <= r_cnt;
            end
          end

          ST_FETCH: begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= '0;
          end

          ST_WAIT: begin
            if (w_wait_end) begin
              r_data  <= i_data;
              r_valid <= 1'b1;
              r_last  <= w_is_last;
              r_state <= ST_SEND;
            end else begin
              r_wait_cnt <= r_wait_cnt + NB_WAIT'(1);
            end
          end

          ST_SEND: begin
            // r_data is untouched here, so it stays stable under backpressure.
            if (w_xfer) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              if (r_last) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
              end else begin
                r_cnt     <= r_cnt + NB_ADDR'(1);
                r_address <= r_cnt + NB_ADDR'(1);
                r_read    <= 1'b1;
                r_state   <= ST_FETCH;
              end
            end
          end

          default: begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_read    = r_read;
  assign o_address = r_address;
  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_last    = r_last;
  assign o_busy    = r_busy;
  assign o_done    = r_done;

endmodule

// File: tb/tb_mem_log_reader.sv
// Bench for mem_log_reader: instance A with RD_LATENCY=1, instance B with
// RD_LATENCY=3. Stimulus pushes expected reads and beats into queues;
// negedge monitors pop and compare whenever the DUT reads or transfers.
module tb_mem_log_reader;

  localparam int NB_ADDR = 15;
  localparam int NB_DATA = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // ---------------- instance A (latency 1)
  logic               a_start = 0, a_abort = 0, a_mem_full = 0, a_ready = 0;
  logic [NB_ADDR-1:0] a_last_addr = '0;
  logic               a_read, a_valid, a_last, a_busy, a_done;
  logic [NB_ADDR-1:0] a_address;
  logic [NB_DATA-1:0] a_i_data, a_data;
  logic [NB_DATA-1:0] a_mem = '0;

  mem_log_reader #(.NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA), .RD_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .i_start(a_start), .i_abort(a_abort),
    .i_last_addr(a_last_addr), .i_mem_full(a_mem_full),
    .o_read(a_read), .o_address(a_address), .i_data(a_i_data),
    .o_data(a_data), .o_valid(a_valid), .i_ready(a_ready),
    .o_last(a_last), .o_busy(a_busy), .o_done(a_done)
  );

  // Memory model: word valid only on the one cycle after the read strobe.
  always @(posedge clk) a_mem <= a_read ? (32'hA5A50000 + 32'(a_address)) : 32'hBAD0BAD0;
  assign a_i_data = a_mem;

  // ---------------- instance B (latency 3)
  logic               b_start = 0, b_abort = 0, b_mem_full = 0, b_ready = 0;
  logic [NB_ADDR-1:0] b_last_addr = '0;
  logic               b_read, b_valid, b_last, b_busy, b_done;
  logic [NB_ADDR-1:0] b_address;
  logic [NB_DATA-1:0] b_i_data, b_data;
  logic [NB_DATA-1:0] b_p0 = '0, b_p1 = '0, b_p2 = '0;

  mem_log_reader #(.NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA), .RD_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst), .i_start(b_start), .i_abort(b_abort),
    .i_last_addr(b_last_addr), .i_mem_full(b_mem_full),
    .o_read(b_read), .o_address(b_address), .i_data(b_i_data),
    .o_data(b_data), .o_valid(b_valid), .i_ready(b_ready),
    .o_last(b_last), .o_busy(b_busy), .o_done(b_done)
  );

  // Three-stage memory pipeline: word valid only on the third cycle.
  always @(posedge clk) begin
    b_p0 <= b_read ? (32'h5A5A0000 + 32'(b_address)) : 32'hBAD1BAD1;
    b_p1 <= b_p0;
    b_p2 <= b_p1;
  end
  assign b_i_data = b_p2;

  // ---------------- scoreboard
  logic [NB_ADDR-1:0] a_addr_q[$], b_addr_q[$];
  logic [NB_DATA:0]   a_beat_q[$], b_beat_q[$];   // {last, data}

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor A
  int                 a_fetch_cyc = 0;
  logic               a_prev_valid = 0, a_prev_stall = 0;
  logic [NB_DATA-1:0] a_prev_data = '0;
  always @(negedge clk) begin
    if (rst) begin
      a_prev_valid = 0;
      a_prev_stall = 0;
    end else begin
      if (a_read) begin
        a_fetch_cyc = cyc;
        if (a_addr_q.size() == 0) chk("A unexpected read", {49'd0, a_address}, 64'hFFFF);
        else chk("A read addr", {49'd0, a_address}, {49'd0, a_addr_q.pop_front()});
      end
      if (a_valid && !a_prev_valid) chk("A valid latency", 64'(cyc - a_fetch_cyc), 64'd2);
      if (a_prev_stall) begin
        chk("A stall valid", {63'd0, a_valid}, 64'd1);
        chk("A stall data", {32'd0, a_data}, {32'd0, a_prev_data});
      end
      if (a_valid && a_ready && !a_abort) begin
        $display("A beat data=%08h last=%0d t=%0t", a_data, a_last, $time);
        if (a_beat_q.size() == 0) chk("A unexpected beat", {32'd0, a_data}, 64'hFFFFFFFFF);
        else begin
          logic [NB_DATA:0] e;
          e = a_beat_q.pop_front();
          chk("A beat data", {32'd0, a_data}, {32'd0, e[NB_DATA-1:0]});
          chk("A beat last", {63'd0, a_last}, {63'd0, e[NB_DATA]});
        end
      end
      a_prev_valid = a_valid;
      a_prev_stall = a_valid && !a_ready && !a_abort;
      a_prev_data  = a_data;
    end
  end

  // Monitor B
  int   b_fetch_cyc = 0;
  logic b_prev_valid = 0;
  always @(negedge clk) begin
    if (rst) begin
      b_prev_valid = 0;
    end else begin
      if (b_read) begin
        b_fetch_cyc = cyc;
        if (b_addr_q.size() == 0) chk("B unexpected read", {49'd0, b_address}, 64'hFFFF);
        else chk("B read addr", {49'd0, b_address}, {49'd0, b_addr_q.pop_front()});
      end
      if (b_valid && !b_prev_valid) chk("B valid latency", 64'(cyc - b_fetch_cyc), 64'd4);
      if (b_valid && b_ready && !b_abort) begin
        $display("B beat data=%08h last=%0d t=%0t", b_data, b_last, $time);
        if (b_beat_q.size() == 0) chk("B unexpected beat", {32'd0, b_data}, 64'hFFFFFFFFF);
        else begin
          logic [NB_DATA:0] e;
          e = b_beat_q.pop_front();
          chk("B beat data", {32'd0, b_data}, {32'd0, e[NB_DATA-1:0]});
          chk("B beat last", {63'd0, b_last}, {63'd0, e[NB_DATA]});
        end
      end
      b_prev_valid = b_valid;
    end
  end

  // Expected reads 0..last and beats for a full walk of instance A.
  task automatic push_walk_a(input int last);
    for (int k = 0; k <= last; k++) begin
      a_addr_q.push_back(NB_ADDR'(k));
      a_beat_q.push_back({(k == last), 32'hA5A50000 + 32'(k)});
    end
  endtask

  task automatic start_a(input int last);
    a_last_addr = NB_ADDR'(last);
    a_start = 1;
    step();
    a_start = 0;
    a_last_addr = '1;   // later changes must not matter
  endtask

  // Wait for o_done with optional 1-0-0-1 backpressure on ready.
  task automatic wait_done_a(input string name, input bit bp);
    logic [3:0] pat;
    int n;
    pat = 4'b1001;
    n = 0;
    while (!a_done && n < 200) begin
      if (bp) a_ready = pat[n % 4];
      step();
      n++;
    end
    a_ready = 1;
    chk(name, {63'd0, a_done}, 64'd1);
    chk({name, " busy"}, {63'd0, a_busy}, 64'd0);
  endtask

  initial begin
    int  n;
    bit  found;

    // Reset state
    step(); step();
    chk("rst valid", {63'd0, a_valid}, 0);
    chk("rst read",  {63'd0, a_read},  0);
    chk("rst busy",  {63'd0, a_busy},  0);
    chk("rst done",  {63'd0, a_done},  0);
    chk("rst last",  {63'd0, a_last},  0);
    chk("rst addr",  {49'd0, a_address}, 0);
    chk("rst data",  {32'd0, a_data},  0);
    chk("rst B valid", {63'd0, b_valid}, 0);
    rst = 0;
    step();

    // Basic walk
    a_mem_full = 1; a_ready = 1;
    push_walk_a(3);
    start_a(3);
    wait_done_a("basic done", 0);
    chk("basic reads left", a_addr_q.size(), 0);
    chk("basic beats left", a_beat_q.size(), 0);
    step();
    chk("done holds", {63'd0, a_done}, 1);

    // Backpressure
    push_walk_a(3);
    start_a(3);
    chk("restart clears done", {63'd0, a_done}, 0);
    wait_done_a("bp done", 1);
    chk("bp beats left", a_beat_q.size(), 0);

    // Armed start
    a_mem_full = 0;
    push_walk_a(3);
    start_a(3);
    for (int i = 0; i < 10; i++) begin
      chk("armed no read", {63'd0, a_read}, 0);
      chk("armed busy", {63'd0, a_busy}, 1);
      step();
    end
    a_mem_full = 1;
    step();
    chk("armed first read", {63'd0, a_read}, 1);
    n = 0;
    while (!a_done && n < 100) begin
      chk("armed busy walk", {63'd0, a_busy}, 1);
      step();
      n++;
    end
    chk("armed done", {63'd0, a_done}, 1);
    chk("armed beats left", a_beat_q.size(), 0);

    // Abort during SEND of word 2 with start and ready also high
    for (int k = 0; k <= 2; k++) a_addr_q.push_back(NB_ADDR'(k));
    for (int k = 0; k <= 1; k++) a_beat_q.push_back({1'b0, 32'hA5A50000 + 32'(k)});
    start_a(7);
    found = 0;
    n = 0;
    while (!found && n < 100) begin
      step();
      n++;
      if (a_valid && a_address == NB_ADDR'(2)) found = 1;
    end
    chk("abort reached word2", {63'd0, found}, 1);
    a_abort = 1; a_start = 1; a_last_addr = NB_ADDR'(5);
    step();
    a_abort = 0; a_start = 0;
    chk("abort valid", {63'd0, a_valid}, 0);
    chk("abort done",  {63'd0, a_done},  0);
    chk("abort busy",  {63'd0, a_busy},  0);
    chk("abort read",  {63'd0, a_read},  0);
    chk("abort last",  {63'd0, a_last},  0);
    for (int i = 0; i < 5; i++) step();
    chk("abort beats left", a_beat_q.size(), 0);
    chk("abort reads left", a_addr_q.size(), 0);
    push_walk_a(1);
    start_a(1);
    wait_done_a("post-abort done", 0);
    chk("post-abort beats left", a_beat_q.size(), 0);

    // Latency 3, single word
    b_mem_full = 1; b_ready = 1;
    b_addr_q.push_back('0);
    b_beat_q.push_back({1'b1, 32'h5A5A0000});
    b_last_addr = '0;
    b_start = 1;
    step();
    b_start = 0;
    n = 0;
    while (!b_done && n < 100) begin
      step();
      n++;
    end
    chk("B done", {63'd0, b_done}, 1);
    chk("B beats left", b_beat_q.size(), 0);
    chk("B reads left", b_addr_q.size(), 0);

    // Asynchronous reset in WAIT of word 1
    a_addr_q.push_back('0);
    a_addr_q.push_back(NB_ADDR'(1));
    a_beat_q.push_back({1'b0, 32'hA5A50000});
    start_a(3);
    found = 0;
    n = 0;
    while (!found && n < 100) begin
      if (a_read && a_address == NB_ADDR'(1)) found = 1;
      else begin
        step();
        n++;
      end
    end
    chk("rst reached word1", {63'd0, found}, 1);
    step();
    chk("rst in wait busy", {63'd0, a_busy}, 1);
    #1 rst = 1;
    #1;
    chk("async rst busy",  {63'd0, a_busy},  0);
    chk("async rst addr",  {49'd0, a_address}, 0);
    chk("async rst read",  {63'd0, a_read},  0);
    chk("async rst valid", {63'd0, a_valid}, 0);
    step();
    rst = 0;
    for (int i = 0; i < 6; i++) step();
    chk("post-rst valid", {63'd0, a_valid}, 0);
    chk("post-rst beats left", a_beat_q.size(), 0);
    chk("post-rst reads left", a_addr_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

endmodule
